// File: rtl/fault_test_pkg.sv
// rtl/fault_test_pkg.sv - shared types and constants for the stuck-at fault test sequencer
package fault_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CMP,
    FIN
  } state_t;

  localparam int DEF_N_IN       = 4;
  localparam int DEF_SETTLE_CYC = 1;

  // MISR polynomial x^16+x^12+x^3+x+1 expressed as the register taps 15,11,2,0
  localparam int                MISR_W    = 16;
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'h8805;

endpackage

// File: rtl/fault_test_misr.sv
// rtl/fault_test_misr.sv - 16-bit signature register folding {cut_z_f, cut_z} in each compare cycle
module fault_test_misr
  import fault_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              update,
  input  logic [1:0]        din,
  output logic [MISR_W-1:0] signature
);

  logic feedback;

  assign feedback = ^(signature & MISR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (update) begin
      signature <= {signature[MISR_W-2:0], feedback} ^ {{(MISR_W-2){1'b0}}, din};
    end
  end

endmodule

// File: rtl/fault_test_ctrl.sv
// rtl/fault_test_ctrl.sv - exhaustive stuck-at fault test sequencer; FAULT_TEST_MISR_EN adds a response signature
module fault_test_ctrl
  import fault_test_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            cut_z,
  input  logic            cut_z_f,
  output logic [N_IN-1:0] pat,
  output logic            fault_inj,
  output logic            busy,
  output logic            done,
  output logic            detected,
  output logic [N_IN-1:0] first_det_pat,
  output logic [N_IN:0]   det_count
`ifdef FAULT_TEST_MISR_EN
  ,
  output logic [MISR_W-1:0] signature
`endif
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          mismatch;

  assign mismatch = cut_z ^ cut_z_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      pat           <= '0;
      fault_inj     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      detected      <= 1'b0;
      first_det_pat <= '0;
      det_count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat           <= '0;
            det_count     <= '0;
            detected      <= 1'b0;
            first_det_pat <= '0;
            busy          <= 1'b1;
            fault_inj     <= 1'b1;
            settle_cnt    <= '0;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (abort) begin
            busy      <= 1'b0;
            fault_inj <= 1'b0;
            state     <= IDLE;
          end else if (settle_cnt == CW'(SETTLE_CYC - 1)) begin
            state <= CMP;
          end
        end
        CMP: begin
          // A mismatch seen in the aborting cycle still counts toward the results
          if (mismatch) begin
            det_count <= det_count + 1'b1;
            if (!detected) first_det_pat <= pat;
            detected <= 1'b1;
          end
          if (abort) begin
            busy      <= 1'b0;
            fault_inj <= 1'b0;
            state     <= IDLE;
          end else if (pat == '1) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            pat        <= pat + 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        FIN: begin
          busy      <= 1'b0;
          fault_inj <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FAULT_TEST_MISR_EN
  fault_test_misr u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    ((state == IDLE) && start),
    .update   (state == CMP),
    .din      ({cut_z_f, cut_z}),
    .signature(signature)
  );
`endif

endmodule
